// File: rtl/seq_pkg.sv
// Shared definitions for the accumulator-machine sequencer: FSM states,
// opcode map, default address width and the opcode classifier.
package seq_pkg;

    localparam int ADDR_W_DEFAULT = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WRITEBACK,
        ST_HALTED
    } state_e;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_JN    = 4'hA;
    localparam logic [3:0] OP_CLR   = 4'hB;
    localparam logic [3:0] OP_SHL   = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_NOPE  = 4'hE;
    localparam logic [3:0] OP_NOPF  = 4'hF;

    typedef enum logic [2:0] {
        CLS_MEM_RD,
        CLS_MEM_WR,
        CLS_JUMP,
        CLS_REG,
        CLS_NONE
    } op_class_e;

    // HALT and the NOPs fall into CLS_NONE; the FSM tells them apart by opcode.
    function automatic op_class_e classify_op(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_LOAD, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR:  cls = CLS_MEM_RD;
            OP_STORE:               cls = CLS_MEM_WR;
            OP_JUMP, OP_JZ, OP_JN:  cls = CLS_JUMP;
            OP_CLR, OP_SHL, OP_SHR: cls = CLS_REG;
            default:                cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ACC-update unit, shared by WRITEBACK (memory operand ops)
// and EXEC (register-only ops). Arithmetic is 16-bit modulo.
module seq_alu
    import seq_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] acc,
    input  logic [15:0] mem_rdata,
    output logic [15:0] acc_next
);

    always_comb begin
        case (opcode)
            OP_LOAD: acc_next = mem_rdata;
            OP_ADD:  acc_next = acc + mem_rdata;
            OP_SUB:  acc_next = acc - mem_rdata;
            OP_AND:  acc_next = acc & mem_rdata;
            OP_OR:   acc_next = acc | mem_rdata;
            OP_XOR:  acc_next = acc ^ mem_rdata;
            OP_CLR:  acc_next = 16'h0000;
            OP_SHL:  acc_next = {acc[14:0], 1'b0};
            OP_SHR:  acc_next = {1'b0, acc[15:1]};
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator machine; owns
// PC, IR and ACC and acts as initiator on the one-cycle-latency memory port.
module control_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic [15:0]       acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       ir_out,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       acc_q, acc_d;

    logic [3:0]        opcode;
    logic [15:0]       operand_addr;
    op_class_e         op_class;
    logic              jump_taken;
    logic [15:0]       alu_acc;

    assign opcode       = ir_q[15:12];
    assign operand_addr = {4'h0, ir_q[11:0]};
    assign op_class     = classify_op(opcode);

    // Conditional jumps look at ACC as it stands in EXEC; there is no flag register.
    always_comb begin
        case (opcode)
            OP_JUMP: jump_taken = 1'b1;
            OP_JZ:   jump_taken = (acc_q == 16'h0000);
            OP_JN:   jump_taken = acc_q[15];
            default: jump_taken = 1'b0;
        endcase
    end

    seq_alu u_alu (
        .opcode    (opcode),
        .acc       (acc_q),
        .mem_rdata (mem_rdata),
        .acc_next  (alu_acc)
    );

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can leave something unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        mem_addr = 16'h0000;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_addr = 16'(pc_q);
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op_class)
                    CLS_MEM_RD: begin
                        mem_addr = operand_addr;
                        state_d  = ST_WRITEBACK;
                    end
                    CLS_MEM_WR: begin
                        mem_addr = operand_addr;
                        mem_we   = 1'b1;
                    end
                    CLS_JUMP: begin
                        if (jump_taken) pc_d = ADDR_W'(ir_q[11:0]);
                    end
                    CLS_REG: begin
                        acc_d = alu_acc;
                    end
                    default: begin
                        if (opcode == OP_HALT) state_d = ST_HALTED;
                    end
                endcase
            end
            ST_WRITEBACK: begin
                acc_d   = alu_acc;
                state_d = ST_FETCH;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= '0;
            ir_q  <= 16'h0000;
            acc_q <= 16'h0000;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
        end
    end

    assign mem_wdata = acc_q;
    assign acc_out   = acc_q;
    assign pc_out    = pc_q;
    assign ir_out    = ir_q;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a one-cycle-latency memory model;
// expected values are hand-computed from the instruction timing.
module tb_control_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] acc_out;
    logic [11:0] pc_out;
    logic [15:0] ir_out;
    logic        halted;

    logic [15:0] mem [0:4095];
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.ADDR_W(12)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .acc_out   (acc_out),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:0]];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we   = 1'b1;
        tick(1);
        ld_we   = 1'b0;
    endtask

    // Releases reset, pulses run and returns #1 after the edge that enters FETCH.
    task automatic start();
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;
        tick(1);
        run     = 1'b0;
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        run     = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        tick(2);

        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_we", {15'h0, mem_we}, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_halted", {15'h0, halted}, 16'h0000);
        check("rst_acc", acc_out, 16'h0000);
        check("rst_pc", {4'h0, pc_out}, 16'h0000);
        check("rst_ir", ir_out, 16'h0000);

        // LOAD / ADD / STORE / HALT
        load(12'h000, 16'h1010);
        load(12'h001, 16'h3011);
        load(12'h002, 16'h2012);
        load(12'h003, 16'h0000);
        load(12'h010, 16'h0005);
        load(12'h011, 16'h0007);
        load(12'h012, 16'h0000);
        start();
        check("t1_fetch_addr", mem_addr, 16'h0000);
        tick(1);
        check("t1_decode_addr", mem_addr, 16'h0000);
        tick(1);
        check("t1_exec_ir", ir_out, 16'h1010);
        check("t1_exec_pc", {4'h0, pc_out}, 16'h0001);
        check("t1_exec_addr", mem_addr, 16'h0010);
        tick(1);
        check("t1_wb_addr", mem_addr, 16'h0000);
        tick(1);
        check("t1_load_acc", acc_out, 16'h0005);
        check("t1_fetch1_addr", mem_addr, 16'h0001);
        tick(4);
        check("t1_add_acc", acc_out, 16'h000C);
        tick(2);
        check("t1_store_we", {15'h0, mem_we}, 16'h0001);
        check("t1_store_addr", mem_addr, 16'h0012);
        check("t1_store_wdata", mem_wdata, 16'h000C);
        tick(1);
        check("t1_fetch3_addr", mem_addr, 16'h0003);
        check("t1_mem12", mem[12'h012], 16'h000C);
        tick(2);
        check("t1_exec_halt_not_yet", {15'h0, halted}, 16'h0000);
        tick(1);
        check("t1_halted", {15'h0, halted}, 16'h0001);
        check("t1_halt_pc", {4'h0, pc_out}, 16'h0004);
        check("t1_halt_acc", acc_out, 16'h000C);

        // run toggling while halted
        for (int i = 0; i < 10; i++) begin
            run = ~run;
            tick(1);
            check("t6_halted", {15'h0, halted}, 16'h0001);
            check("t6_we", {15'h0, mem_we}, 16'h0000);
            check("t6_addr", mem_addr, 16'h0000);
        end
        check("t6_pc", {4'h0, pc_out}, 16'h0004);
        run = 1'b0;

        // ADD wraps to zero, JZ taken
        reset_n = 1'b0;
        load(12'h000, 16'h1030);
        load(12'h001, 16'h3031);
        load(12'h002, 16'h9020);
        load(12'h020, 16'h0000);
        load(12'h030, 16'hFFFF);
        load(12'h031, 16'h0001);
        start();
        tick(8);
        check("t2_acc_zero", acc_out, 16'h0000);
        check("t2_fetch_jz", mem_addr, 16'h0002);
        tick(2);
        check("t2_exec_pc", {4'h0, pc_out}, 16'h0003);
        tick(1);
        check("t2_jz_pc", {4'h0, pc_out}, 16'h0020);
        check("t2_jz_fetch", mem_addr, 16'h0020);
        tick(3);
        check("t2_halted", {15'h0, halted}, 16'h0001);
        check("t2_halt_pc", {4'h0, pc_out}, 16'h0021);

        // PC wrap at 0xFFF
        reset_n = 1'b0;
        load(12'h000, 16'h8FFF);
        load(12'hFFF, 16'hE000);
        start();
        tick(3);
        check("t3_fetch_fff", mem_addr, 16'h0FFF);
        check("t3_pc_fff", {4'h0, pc_out}, 16'h0FFF);
        tick(2);
        check("t3_exec_pc_wrap", {4'h0, pc_out}, 16'h0000);
        check("t3_exec_ir", ir_out, 16'hE000);
        tick(1);
        check("t3_fetch_wrap", mem_addr, 16'h0000);
        tick(3);
        check("t3_loop_fetch", mem_addr, 16'h0FFF);

        // Reset during STORE EXEC
        reset_n = 1'b0;
        load(12'h000, 16'h1050);
        load(12'h001, 16'h2051);
        load(12'h050, 16'h1234);
        load(12'h051, 16'hBEEF);
        start();
        tick(6);
        check("t4_store_we", {15'h0, mem_we}, 16'h0001);
        check("t4_store_addr", mem_addr, 16'h0051);
        check("t4_store_wdata", mem_wdata, 16'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        check("t4_we_dropped", {15'h0, mem_we}, 16'h0000);
        check("t4_addr_zero", mem_addr, 16'h0000);
        check("t4_pc_zero", {4'h0, pc_out}, 16'h0000);
        check("t4_acc_zero", acc_out, 16'h0000);
        check("t4_ir_zero", ir_out, 16'h0000);
        tick(2);
        check("t4_mem_unchanged", mem[12'h051], 16'hBEEF);

        // SHL / SHR / JN not taken
        load(12'h000, 16'h1060);
        load(12'h001, 16'hC000);
        load(12'h002, 16'hD000);
        load(12'h003, 16'hA070);
        load(12'h004, 16'h0000);
        load(12'h060, 16'h8001);
        start();
        tick(4);
        check("t5_load_acc", acc_out, 16'h8001);
        tick(3);
        check("t5_shl_acc", acc_out, 16'h0002);
        check("t5_shl_next_addr", mem_addr, 16'h0002);
        tick(3);
        check("t5_shr_acc", acc_out, 16'h0001);
        tick(3);
        check("t5_jn_nt_addr", mem_addr, 16'h0004);
        check("t5_jn_nt_pc", {4'h0, pc_out}, 16'h0004);
        tick(3);
        check("t5_halted", {15'h0, halted}, 16'h0001);

        // SUB / AND / OR / XOR, JN taken, CLR
        reset_n = 1'b0;
        load(12'h000, 16'h1080);
        load(12'h001, 16'h4081);
        load(12'h002, 16'h5082);
        load(12'h003, 16'h6083);
        load(12'h004, 16'h7084);
        load(12'h005, 16'hA007);
        load(12'h006, 16'h0000);
        load(12'h007, 16'hB000);
        load(12'h008, 16'h0000);
        load(12'h080, 16'h0F0F);
        load(12'h081, 16'h0010);
        load(12'h082, 16'h00FF);
        load(12'h083, 16'h1200);
        load(12'h084, 16'hFFFF);
        start();
        tick(4);
        check("t7_load", acc_out, 16'h0F0F);
        tick(4);
        check("t7_sub", acc_out, 16'h0EFF);
        tick(4);
        check("t7_and", acc_out, 16'h00FF);
        tick(4);
        check("t7_or", acc_out, 16'h12FF);
        tick(4);
        check("t7_xor", acc_out, 16'hED00);
        tick(3);
        check("t7_jn_taken_addr", mem_addr, 16'h0007);
        tick(3);
        check("t7_clr", acc_out, 16'h0000);
        check("t7_clr_next_addr", mem_addr, 16'h0008);
        tick(3);
        check("t7_halted", {15'h0, halted}, 16'h0001);
        check("t7_halt_pc", {4'h0, pc_out}, 16'h0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction-sequencing controller for the 16-bit accumulator machine. It is the initiator on the main-memory port: it drives address, write data and write enable, and consumes the one-cycle-latency registered read data. It owns PC, IR and ACC and runs a fetch/decode/execute loop until it executes HALT. It sits between the main memory and the top-level computer, replacing the hand-wired register instances.

## Interface
Parameters:
- `ADDR_W`, default 12, width of the instruction address field and the PC. `mem_addr` is this value zero-extended to 16 bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `run` input 1: leaves IDLE when high. Sampled only in IDLE.
- `mem_rdata` input 16: memory read data, valid the cycle after the address is presented with `mem_we`=0.
- `mem_addr` output 16: memory address.
- `mem_wdata` output 16: memory write data, equal to ACC.
- `mem_we` output 1: memory write enable; the memory writes on the rising edge while this is high.
- `acc_out` output 16: current ACC.
- `pc_out` output ADDR_W: current PC.
- `ir_out` output 16: current IR.
- `halted` output 1: high while in HALTED.

## Operation
- Instruction format: opcode is IR[15:12]; operand address is IR[11:0].
- Opcode map:
  - 0 HALT
  - 1 LOAD: ACC=M
  - 2 STORE: M=ACC
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: ACC = ACC op M
  - 8 JUMP
  - 9 JZ: jump if ACC==0
  - A JN: jump if ACC[15]
  - B CLR: ACC=0
  - C SHL: ACC<<1, zero fill
  - D SHR: ACC>>1, logical
  - E, F: NOP
- States: IDLE, FETCH, DECODE, EXEC, WRITEBACK, HALTED.
  - IDLE: `mem_we`=0. Go to FETCH when `run`=1.
  - FETCH: `mem_addr`=PC, `mem_we`=0. Go to DECODE.
  - DECODE: IR<=`mem_rdata`; PC<=PC+1, wrapping from 0xFFF to 0x000. Go to EXEC.
  - EXEC: decode from IR.
    - Memory-read ops (1, 3-7): `mem_addr`=IR[11:0], `mem_we`=0. Go to WRITEBACK.
    - STORE: `mem_addr`=IR[11:0], `mem_we`=1. Go to FETCH.
    - JUMP, and JZ/JN when taken: PC<=IR[11:0]. Go to FETCH.
    - CLR, SHL, SHR: update ACC. Go to FETCH.
    - NOP, and JZ/JN when not taken: go to FETCH.
    - HALT: go to HALTED.
  - WRITEBACK: ACC<=f(ACC, `mem_rdata`). Go to FETCH.
  - HALTED: terminal. Only `reset_n` exits it; `run` is ignored.
- Arithmetic is 16-bit modulo. ADD/SUB carry and borrow are discarded. No flags register; JZ and JN test ACC live in EXEC.
- `mem_addr` is 0 in IDLE, DECODE, WRITEBACK and HALTED.
- `mem_we` is decoded combinationally from the state register and IR. It can be high only in EXEC with opcode 2, so an asynchronous reset forces it low immediately.
- Reset values: state=IDLE, PC=0, IR=0, ACC=0, so `mem_addr`=0, `mem_we`=0, `mem_wdata`=0 and `halted`=0.

## Timing
- Instruction latency from FETCH entry to the next FETCH entry:
  - LOAD/ADD/SUB/AND/OR/XOR: 4 cycles.
  - STORE, JUMP, JZ, JN, CLR, SHL, SHR, NOP: 3 cycles.
- Read data is sampled exactly one cycle after its address; there is no wait-state input.
- STORE write data is ACC as it stands in EXEC.
- PC wrap: fetching at 0xFFF produces PC=0x000 in EXEC. A taken jump in EXEC overrides the DECODE increment.
- A jump to its own address loops forever at 3 cycles per iteration. This is legal, not an error.
- Reset asserted mid-instruction: all state returns to reset values asynchronously. An in-flight STORE is dropped if reset lands before the write edge.
- `run` deasserted after leaving IDLE has no effect.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum;
  - the opcode constants OP_HALT … OP_NOPF;
  - the `ADDR_W` default;
  - a function classifying opcodes as mem-read, mem-write, jump or register ops.
- One natural sub-module, `seq_alu`: combinational ACC-update unit taking (opcode, ACC, `mem_rdata`) and returning the next ACC. It is shared by WRITEBACK and the EXEC register ops.
- The FSM, PC, IR and ACC registers stay in `control_sequencer`.

## Test plan
1. Reset, then `run`=1. Program M[0]=0x1010 (LOAD 0x10), M[1]=0x3011 (ADD 0x11), M[2]=0x2012 (STORE 0x12), M[3]=0x0000, with M[0x10]=0x0005 and M[0x11]=0x0007 → M[0x12]=0x000C, `halted`=1 after 4+4+3 cycles plus HALT, PC=0x004.
2. ACC=0xFFFF, ADD M=0x0001 → ACC=0x0000. Next instruction JZ 0x020 → PC=0x020, and FETCH drives `mem_addr`=0x0020.
3. PC=0xFFF holding a NOP → PC=0x000 afterwards, and the next FETCH address is 0x0000.
4. Assert `reset_n` low during the EXEC cycle of a STORE → `mem_we` drops in the same cycle, the target word is unchanged, and PC/ACC/IR read 0.
5. ACC=0x8001: SHL → 0x0002; SHR → 0x0001; JN not taken → 3 cycles, PC advances by 1.
6. After HALT, toggle `run` for 10 cycles → state stays HALTED, `mem_we`=0, `mem_addr`=0.
